// File: rtl/sram_arbiter_pkg.sv
// Shared VideoCore SRAM arbiter types: bus widths, FSM state encodings and requester IDs.
// The optional starvation guard is enabled with SRAM_ARB_STARVATION_GUARD_EN.
package sram_arbiter_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD1,
        ST_RD2,
        ST_WR1,
        ST_WR2,
        ST_WR3
    } arb_state_e;

    typedef enum logic {
        REQ_VID  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_e;

endpackage

// File: rtl/sram_arb_grant.sv
// Priority decision between video and host; with SRAM_ARB_STARVATION_GUARD_EN defined, a burst
// counter forces a host grant after VID_BURST_MAX consecutive video grants while the host waits.
module sram_arb_grant
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned VID_BURST_MAX = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    vid_req,
    input  logic    host_req,
    input  logic    arb_en,
    output logic    grant_valid,
    output req_id_e grant_id
);

`ifdef SRAM_ARB_STARVATION_GUARD_EN
    localparam int unsigned CntW = $clog2(VID_BURST_MAX + 1);

    logic [CntW-1:0] burst;
    logic            host_due;

    assign host_due = host_req && (burst >= CntW'(VID_BURST_MAX));

    always_comb begin
        grant_valid = vid_req | host_req;
        grant_id    = (vid_req && !host_due) ? REQ_VID : REQ_HOST;
    end

    // Counts only video grants made while the host is actually waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst <= '0;
        end else if (!host_req) begin
            burst <= '0;
        end else if (arb_en && grant_valid) begin
            if (grant_id == REQ_HOST) begin
                burst <= '0;
            end else begin
                burst <= burst + CntW'(1);
            end
        end
    end
`else
    logic unused_guard;

    assign unused_guard = clk ^ rst_n ^ arb_en ^ (VID_BURST_MAX == 0);

    always_comb begin
        grant_valid = vid_req | host_req;
        grant_id    = vid_req ? REQ_VID : REQ_HOST;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the video scanout read port and the host read/write port.
// Build with SRAM_ARB_STARVATION_GUARD_EN to bound video bursts while the host is waiting.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = SRAM_ADDR_W,
    parameter int unsigned DATA_W        = SRAM_DATA_W,
    parameter int unsigned VID_BURST_MAX = 8
) (
    input  logic              i_master_clk,
    input  logic              i_reset_n,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_ack,
    output logic [DATA_W-1:0] o_vid_rdata,
    output logic              o_vid_rvalid,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_rvalid,
    output logic [ADDR_W-1:0] o_sram_address,
    output logic [DATA_W-1:0] o_sram_data_out,
    input  logic [DATA_W-1:0] i_sram_data_in,
    output logic              o_sram_data_dir_out,
    output logic              o_sram_cs_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    arb_state_e state;
    logic       rd_host;
    logic       arb_pt;
    logic       grant_valid;
    req_id_e    grant_id;

    assign arb_pt = (state == ST_IDLE) || (state == ST_RD2) || (state == ST_WR3);

    sram_arb_grant #(
        .VID_BURST_MAX(VID_BURST_MAX)
    ) u_grant (
        .clk        (i_master_clk),
        .rst_n      (i_reset_n),
        .vid_req    (i_vid_req),
        .host_req   (i_host_req),
        .arb_en     (arb_pt),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= ST_IDLE;
            rd_host             <= 1'b0;
            o_vid_ack           <= 1'b0;
            o_vid_rdata         <= '0;
            o_vid_rvalid        <= 1'b0;
            o_host_ack          <= 1'b0;
            o_host_rdata        <= '0;
            o_host_rvalid       <= 1'b0;
            o_sram_address      <= '0;
            o_sram_data_out     <= '0;
            o_sram_data_dir_out <= 1'b0;
            o_sram_cs_n         <= 1'b1;
            o_sram_oe_n         <= 1'b1;
            o_sram_we_n         <= 1'b1;
        end else begin
            o_vid_ack     <= 1'b0;
            o_host_ack    <= 1'b0;
            o_vid_rvalid  <= 1'b0;
            o_host_rvalid <= 1'b0;

            // Read data is captured at the end of RD2, presented the cycle after.
            if (state == ST_RD2) begin
                if (rd_host) begin
                    o_host_rdata  <= i_sram_data_in;
                    o_host_rvalid <= 1'b1;
                end else begin
                    o_vid_rdata  <= i_sram_data_in;
                    o_vid_rvalid <= 1'b1;
                end
            end

            case (state)
                ST_RD1: state <= ST_RD2;
                ST_WR1: begin
                    state       <= ST_WR2;
                    o_sram_we_n <= 1'b0;
                end
                ST_WR2: begin
                    state       <= ST_WR3;
                    o_sram_we_n <= 1'b1;
                end
                default: begin
                    // Arbitration point: IDLE, RD2 or WR3.
                    if (grant_valid) begin
                        o_sram_cs_n <= 1'b0;
                        if (grant_id == REQ_VID) begin
                            o_vid_ack           <= 1'b1;
                            o_sram_address      <= i_vid_addr;
                            o_sram_oe_n         <= 1'b0;
                            o_sram_data_dir_out <= 1'b0;
                            rd_host             <= 1'b0;
                            state               <= ST_RD1;
                        end else begin
                            o_host_ack     <= 1'b1;
                            o_sram_address <= i_host_addr;
                            if (i_host_we) begin
                                o_sram_data_out     <= i_host_wdata;
                                o_sram_oe_n         <= 1'b1;
                                o_sram_data_dir_out <= 1'b1;
                                state               <= ST_WR1;
                            end else begin
                                o_sram_oe_n         <= 1'b0;
                                o_sram_data_dir_out <= 1'b0;
                                rd_host             <= 1'b1;
                                state               <= ST_RD1;
                            end
                        end
                    end else begin
                        o_sram_cs_n         <= 1'b1;
                        o_sram_oe_n         <= 1'b1;
                        o_sram_data_dir_out <= 1'b0;
                        state               <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model plus directed scenarios; honours
// SRAM_ARB_STARVATION_GUARD_EN for the expected host wait under continuous video.
module tb_sram_arbiter;

    typedef struct {
        int          due;
        logic [23:0] data;
    } exp_t;

`ifdef SRAM_ARB_STARVATION_GUARD_EN
    localparam int ExpVidBeforeHost = 8;
`else
    localparam int ExpVidBeforeHost = 20;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [19:0] vid_addr = '0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [19:0] host_addr = '0;
    logic [23:0] host_wdata = '0;
    logic        vid_ack, vid_rvalid, host_ack, host_rvalid;
    logic [23:0] vid_rdata, host_rdata, sram_dout, sram_din;
    logic [19:0] sram_addr;
    logic        sram_dir, sram_cs_n, sram_oe_n, sram_we_n;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int n_vid_ack, n_host_ack, vid_acks_at_host, n_vid_rv, n_host_rv;
    int last_vid_rv_cyc, last_host_rv_cyc;
    int n_we_low, n_dir, n_oe_low, n_contention;

    logic [23:0] pin_mem [256];
    logic [23:0] ref_mem [256];
    exp_t        vq[$];
    exp_t        hq[$];

    sram_arbiter dut (
        .i_master_clk       (clk),
        .i_reset_n          (rst_n),
        .i_vid_req          (vid_req),
        .i_vid_addr         (vid_addr),
        .o_vid_ack          (vid_ack),
        .o_vid_rdata        (vid_rdata),
        .o_vid_rvalid       (vid_rvalid),
        .i_host_req         (host_req),
        .i_host_we          (host_we),
        .i_host_addr        (host_addr),
        .i_host_wdata       (host_wdata),
        .o_host_ack         (host_ack),
        .o_host_rdata       (host_rdata),
        .o_host_rvalid      (host_rvalid),
        .o_sram_address     (sram_addr),
        .o_sram_data_out    (sram_dout),
        .i_sram_data_in     (sram_din),
        .o_sram_data_dir_out(sram_dir),
        .o_sram_cs_n        (sram_cs_n),
        .o_sram_oe_n        (sram_oe_n),
        .o_sram_we_n        (sram_we_n)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Power-up SRAM contents; 0x10 holds the test-1 pattern.
    function automatic logic [23:0] dflt(input logic [7:0] a);
        dflt = (a == 8'h10) ? 24'hABCDEF : {a ^ 8'h5A, a, 8'hC3};
    endfunction

    // Pin-level async SRAM: only drives valid data while selected and output-enabled.
    assign sram_din = (!sram_cs_n && !sram_oe_n) ? pin_mem[sram_addr[7:0]] : 24'hDEAD00;

    initial begin
        for (int i = 0; i < 256; i++) pin_mem[i] = dflt(i[7:0]);
        forever begin
            @(posedge clk);
            if (!sram_cs_n && !sram_we_n && sram_dir) pin_mem[sram_addr[7:0]] = sram_dout;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clear_stats();
        n_vid_ack = 0; n_host_ack = 0; vid_acks_at_host = -1; n_vid_rv = 0; n_host_rv = 0;
        last_vid_rv_cyc = -1; last_host_rv_cyc = -1;
        n_we_low = 0; n_dir = 0; n_oe_low = 0; n_contention = 0;
    endtask

    task automatic vid_read(input logic [19:0] addr, input bit hold, output int ack_cyc);
        vid_addr = addr;
        vid_req  = 1'b1;
        ack_cyc  = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (vid_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) begin
            n_total++;
            $display("FAIL vid_ack_timeout: got no ack, expected ack within 200 cycles");
        end
        @(posedge clk);
        #1;
        if (!hold) vid_req = 1'b0;
    endtask

    task automatic host_acc(input bit we, input logic [19:0] addr, input logic [23:0] wdata,
                            input bit hold, output int ack_cyc);
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        host_req   = 1'b1;
        ack_cyc    = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (host_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) begin
            n_total++;
            $display("FAIL host_ack_timeout: got no ack, expected ack within 200 cycles");
        end
        @(posedge clk);
        #1;
        if (!hold) host_req = 1'b0;
    endtask

    // Per-cycle compare against the transaction model.
    initial begin
        exp_t e;
        bit   exp_v, exp_h;
        bit   prev_vreq = 1'b0, prev_vack = 1'b0, prev_hreq = 1'b0, prev_hack = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = dflt(i[7:0]);
        clear_stats();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vq.delete();
                hq.delete();
                prev_vreq = 1'b0; prev_hreq = 1'b0;
                check("rst_pins", 32'({sram_cs_n, sram_oe_n, sram_we_n, sram_dir}), 32'hE);
                check("rst_handshake", 32'({vid_ack, vid_rvalid, host_ack, host_rvalid}), 32'h0);
                check("rst_addr", 32'(sram_addr), 32'h0);
            end else begin
                exp_v = (vq.size() > 0) && (vq[0].due == cyc);
                check("vid_rvalid", 32'(vid_rvalid), 32'(exp_v));
                if (exp_v) begin
                    check("vid_rdata", 32'(vid_rdata), 32'(vq[0].data));
                    vq.delete(0);
                end
                exp_h = (hq.size() > 0) && (hq[0].due == cyc);
                check("host_rvalid", 32'(host_rvalid), 32'(exp_h));
                if (exp_h) begin
                    check("host_rdata", 32'(host_rdata), 32'(hq[0].data));
                    hq.delete(0);
                end
                if (vid_rvalid) begin n_vid_rv++; last_vid_rv_cyc = cyc; end
                if (host_rvalid) begin n_host_rv++; last_host_rv_cyc = cyc; end

                if (host_ack) begin
                    n_host_ack++;
                    vid_acks_at_host = n_vid_ack;
                    check("host_ack_req", 32'(host_req), 32'h1);
                    check("host_ack_addr", 32'(sram_addr), 32'(host_addr));
                    if (host_we) begin
                        check("host_wr1_pins",
                              32'({sram_cs_n, sram_oe_n, sram_we_n, sram_dir}), 32'h7);
                        check("host_wr_data", 32'(sram_dout), 32'(host_wdata));
                        ref_mem[host_addr[7:0]] = host_wdata;
                    end else begin
                        check("host_rd1_pins",
                              32'({sram_cs_n, sram_oe_n, sram_we_n, sram_dir}), 32'h2);
                        e.due = cyc + 2;
                        e.data = ref_mem[host_addr[7:0]];
                        hq.push_back(e);
                    end
                end
                if (vid_ack) begin
                    n_vid_ack++;
                    check("vid_ack_req", 32'(vid_req), 32'h1);
                    check("vid_ack_addr", 32'(sram_addr), 32'(vid_addr));
                    check("vid_rd1_pins",
                          32'({sram_cs_n, sram_oe_n, sram_we_n, sram_dir}), 32'h2);
                    e.due = cyc + 2;
                    e.data = ref_mem[vid_addr[7:0]];
                    vq.push_back(e);
                end
                check("ack_exclusive", 32'(vid_ack & host_ack), 32'h0);
                check("bus_contention", 32'(!sram_oe_n && sram_dir), 32'h0);
                if (!sram_oe_n && sram_dir) n_contention++;
                if (!sram_we_n) begin
                    n_we_low++;
                    check("we_pins", 32'({sram_cs_n, sram_oe_n, sram_dir}), 32'h3);
                end
                if (sram_dir) n_dir++;
                if (!sram_oe_n) n_oe_low++;
                if (prev_vreq && !prev_vack) check("vid_req_held", 32'(vid_req), 32'h1);
                if (prev_hreq && !prev_hack) check("host_req_held", 32'(host_req), 32'h1);
                prev_vreq = vid_req; prev_vack = vid_ack;
                prev_hreq = host_req; prev_hack = host_ack;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, a2, va, ha, s, prev_h;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: single video read
        @(posedge clk); #1;
        clear_stats();
        vid_read(20'h00010, 1'b0, a);
        check("t1_rd2_pins", 32'({sram_cs_n, sram_oe_n}), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("t1_rvalid", 32'(vid_rvalid), 32'h1);
        check("t1_rdata", 32'(vid_rdata), 32'hABCDEF);
        check("t1_latency", 32'(last_vid_rv_cyc - a), 32'd2);
        check("t1_oe_cycles", 32'(n_oe_low), 32'd2);
        check("t1_idle_cs", 32'(sram_cs_n), 32'h1);

        // 2: host write then readback
        @(posedge clk); #1;
        clear_stats();
        host_acc(1'b1, 20'hFFFFF, 24'h123456, 1'b0, a);
        repeat (4) @(negedge clk);
        #1;
        check("t2_we_cycles", 32'(n_we_low), 32'd1);
        check("t2_dir_cycles", 32'(n_dir), 32'd3);
        check("t2_no_rvalid", 32'(n_host_rv), 32'd0);
        @(posedge clk); #1;
        host_acc(1'b0, 20'hFFFFF, 24'h0, 1'b0, a);
        repeat (2) @(negedge clk);
        #1;
        check("t2_rd_rvalid", 32'(host_rvalid), 32'h1);
        check("t2_rd_data", 32'(host_rdata), 32'h123456);
        check("t2_rd_latency", 32'(last_host_rv_cyc - a), 32'd2);

        // 3: simultaneous requests
        @(posedge clk); #1;
        clear_stats();
        fork
            vid_read(20'h00020, 1'b0, va);
            host_acc(1'b1, 20'h00030, 24'h0A0B0C, 1'b0, ha);
        join
        check("t3_host_after_vid", 32'(ha - va), 32'd2);
        repeat (5) @(negedge clk);

        // 4: continuous video with a pending host write
        @(posedge clk); #1;
        clear_stats();
        fork
            begin
                int t;
                for (int i = 0; i < 20; i++) vid_read(20'h00060 + 20'(i), (i < 19), t);
            end
            host_acc(1'b1, 20'h00090, 24'h5555AA, 1'b0, ha);
        join
        repeat (4) @(negedge clk);
        #1;
        check("t4_vid_before_host", 32'(vid_acks_at_host), 32'(ExpVidBeforeHost));
        check("t4_vid_total", 32'(n_vid_ack), 32'd20);

        // 5: reset during WR2
        @(posedge clk); #1;
        host_acc(1'b1, 20'h00040, 24'h777777, 1'b0, a);
        check("t5_wr2_we", 32'(sram_we_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_pins", 32'({sram_cs_n, sram_we_n, sram_dir}), 32'h6);
        clear_stats();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("t5_no_ack", 32'(n_vid_ack + n_host_ack), 32'd0);
        check("t5_no_rvalid", 32'(n_vid_rv + n_host_rv), 32'd0);
        check("t5_idle_cs", 32'(sram_cs_n), 32'h1);
        @(posedge clk); #1;
        s = cyc;
        vid_read(20'h00010, 1'b0, a);
        check("t5_idle_ack_latency", 32'(a - s), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("t5_rdata", 32'(vid_rdata), 32'hABCDEF);

        // 6: alternating host write / video read, back to back
        @(posedge clk); #1;
        clear_stats();
        prev_h = -1;
        for (int i = 1; i <= 4; i++) begin
            fork
                vid_read(20'h0004F + 20'(i), 1'b0, va);
                host_acc(1'b1, 20'h00050 + 20'(i), 24'h0C0000 + 24'(i), 1'b0, ha);
            join
            check("t6_rd2_to_wr1", 32'(ha - va), 32'd2);
            if (prev_h >= 0) check("t6_wr3_to_rd1", 32'(va - prev_h), 32'd3);
            prev_h = ha;
        end
        repeat (5) @(negedge clk);
        #1;
        check("t6_contention", 32'(n_contention), 32'd0);
        check("t6_ack_counts", 32'({n_vid_ack[7:0], n_host_ack[7:0]}), 32'h0404);
        check("t6_vid_rvalids", 32'(n_vid_rv), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
